// File: rtl/cla_pkg.sv
// Shared lookahead helpers and configuration checks for the pipelined CLA adder/subtractor.
package cla_pkg;

  // Widest P/G vector the helpers accept; callers pad unused upper positions with P=1, G=0.
  localparam int unsigned MAX_LA = 32;

  // Group propagate/generate: P = AND of all p, G = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0].
  function automatic logic [1:0] group_pg(input logic [MAX_LA-1:0] p,
                                          input logic [MAX_LA-1:0] g);
    logic pp;
    logic gg;
    logic term;
    pp = &p;
    gg = 1'b0;
    for (int i = 0; i < int'(MAX_LA); i++) begin
      term = g[i];
      for (int j = i + 1; j < int'(MAX_LA); j++) begin
        term = term & p[j];
      end
      gg = gg | term;
    end
    return {pp, gg};
  endfunction

  // Flattened lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i]); c[0] = cin.
  function automatic logic [MAX_LA:0] lookahead_carry(input logic [MAX_LA-1:0] p,
                                                      input logic [MAX_LA-1:0] g,
                                                      input logic              cin);
    logic [MAX_LA:0] c;
    logic            term;
    logic            ci;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(MAX_LA); i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) begin
        term = term & p[j];
      end
      ci = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        ci = ci | term;
      end
      c[i+1] = ci;
    end
    return c;
  endfunction

  // Legal configurations: whole groups, whole stages, group size 2..8, stage lookahead fits MAX_LA.
  function automatic logic cfg_ok(input int unsigned width,
                                  input int unsigned group,
                                  input int unsigned stages);
    logic ok;
    ok = (group >= 2) && (group <= 8) && (stages >= 1) && (width >= group);
    if (ok) begin
      ok = ((width % group) == 0) && (((width / group) % stages) == 0)
           && (((width / group) / stages) < MAX_LA);
    end
    return ok;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: bit-level carries resolved in parallel from cin, plus group P/G.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             P,
  output logic             G
);

  logic [GROUP-1:0]  p;
  logic [GROUP-1:0]  g;
  logic [MAX_LA-1:0] p_ext;
  logic [MAX_LA-1:0] g_ext;
  logic [MAX_LA:0]   c;
  logic [1:0]        pg;
  logic              unused_c;

  assign p = a ^ b;
  assign g = a & b;

  // Pad above the group with transparent positions so helper results equal the GROUP-bit ones.
  assign p_ext = {{(MAX_LA - GROUP){1'b1}}, p};
  assign g_ext = {{(MAX_LA - GROUP){1'b0}}, g};

  assign pg = group_pg(p_ext, g_ext);
  assign P  = pg[1];
  assign G  = pg[0];

  assign c   = lookahead_carry(p_ext, g_ext, cin);
  assign sum = p ^ c[GROUP-1:0];

  assign unused_c = ^c[MAX_LA:GROUP];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with elastic valid/ready stages and result flags.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned NG   = WIDTH / GROUP;
  localparam int unsigned GPS  = NG / STAGES;
  localparam int unsigned SW   = GPS * GROUP;
  localparam int unsigned LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_bad_cfg
    $error("cla_pipe_addsub: illegal WIDTH/GROUP/STAGES combination");
  end

  // Per-stage registers (full width kept for uniform indexing; unresolved upper bits ride along).
  logic [STAGES-1:0]              vld;
  logic [STAGES-1:0]              c_r;
  logic [STAGES-1:0][WIDTH-1:0]   a_r;
  logic [STAGES-1:0][WIDTH-1:0]   bx_r;
  logic [STAGES-1:0][WIDTH-1:0]   sum_r;
  logic                           ovf_r;
  logic                           zero_r;

  // Stage inputs and combinational results.
  logic [STAGES-1:0]              src_v;
  logic [STAGES-1:0]              src_c;
  logic [STAGES-1:0][WIDTH-1:0]   src_a;
  logic [STAGES-1:0][WIDTH-1:0]   src_bx;
  logic [STAGES-1:0][WIDTH-1:0]   src_sum;
  logic [STAGES-1:0][WIDTH-1:0]   nxt_sum;
  logic [STAGES-1:0][MAX_LA:0]    stg_c;
  logic [STAGES-1:0]              rdy;
  logic [WIDTH-1:0]               grp_sum;
  logic [NG-1:0]                  grp_p;
  logic [NG-1:0]                  grp_g;
  logic [NG-1:0]                  grp_cin;
  logic                           c_msb;
  logic                           ovf_nxt;
  logic [STAGES-1:0]              unused_la;
  logic                           unused_pipe;

  // Stage 0 works on the live operands (Bx and c0 formed here); later stages on the previous registers.
  always_comb begin
    src_v   = '0;
    src_c   = '0;
    src_a   = '0;
    src_bx  = '0;
    src_sum = '0;
    src_v[0]  = in_valid;
    src_a[0]  = A;
    src_bx[0] = Sub ? ~B : B;
    src_c[0]  = Cin ^ Sub;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_v[k]   = vld[k-1];
      src_a[k]   = a_r[k-1];
      src_bx[k]  = bx_r[k-1];
      src_c[k]   = c_r[k-1];
      src_sum[k] = sum_r[k-1];
    end
  end

  // Backward ready chain: a stage may load if empty or its content moves on this cycle.
  always_comb begin
    rdy       = '0;
    rdy[LAST] = !vld[LAST] || out_ready;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  // Group instances and the second-level lookahead across the groups owned by each stage.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    assign stg_c[k] = lookahead_carry({{(MAX_LA - GPS){1'b1}}, grp_p[k*GPS +: GPS]},
                                      {{(MAX_LA - GPS){1'b0}}, grp_g[k*GPS +: GPS]},
                                      src_c[k]);
    assign unused_la[k] = ^stg_c[k][MAX_LA:GPS+1];

    for (genvar j = 0; j < int'(GPS); j++) begin : g_grp
      localparam int unsigned GI = k * GPS + j;
      assign grp_cin[GI] = stg_c[k][j];
      cla_group #(.GROUP(GROUP)) u_grp (
        .a   (src_a[k][GI*GROUP +: GROUP]),
        .b   (src_bx[k][GI*GROUP +: GROUP]),
        .cin (grp_cin[GI]),
        .sum (grp_sum[GI*GROUP +: GROUP]),
        .P   (grp_p[GI]),
        .G   (grp_g[GI])
      );
    end
  end

  // Merge each stage's freshly resolved slice into the partial sum it inherits.
  always_comb begin
    nxt_sum = src_sum;
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt_sum[k][k*SW +: SW] = grp_sum[k*SW +: SW];
    end
  end

  // Carry into the MSB recovered from sum = p ^ c; overflow is that carry against carry-out.
  assign c_msb   = nxt_sum[LAST][WIDTH-1] ^ src_a[LAST][WIDTH-1] ^ src_bx[LAST][WIDTH-1];
  assign ovf_nxt = c_msb ^ stg_c[LAST][GPS];

  // Stage registers: hold on stall, load on ready, flags captured with the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      c_r    <= '0;
      a_r    <= '0;
      bx_r   <= '0;
      sum_r  <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          vld[k] <= src_v[k];
          if (src_v[k]) begin
            a_r[k]   <= src_a[k];
            bx_r[k]  <= src_bx[k];
            sum_r[k] <= nxt_sum[k];
            c_r[k]   <= stg_c[k][GPS];
          end
        end
      end
      if (rdy[LAST] && src_v[LAST]) begin
        ovf_r  <= ovf_nxt;
        zero_r <= ~|nxt_sum[LAST];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[LAST];
  assign Sum       = sum_r[LAST];
  assign Cout      = c_r[LAST];
  assign Ovf       = ovf_r;
  assign Zero      = zero_r;

  assign unused_pipe = ^{a_r[LAST], bx_r[LAST], unused_la};

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=32, GROUP=4, STAGES=4).
module tb_cla_pipe_addsub;

  localparam int unsigned W  = 32;
  localparam int unsigned ST = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         Zero;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(W), .GROUP(4), .STAGES(ST)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {cout, ovf, zero, sum} from plain 33-bit arithmetic and sign rules.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] bx;
    logic [32:0] s;
    logic        ovf;
    bx  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bx} + {32'd0, cin ^ sub};
    ovf = (a[31] == bx[31]) && (s[31] != a[31]);
    return {s[32], ovf, (s[31:0] == 32'd0), s[31:0]};
  endfunction

  // One isolated beat: result must appear on the ST-th rising edge, counting the accepting edge.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
    int lat;
    A = a; B = b; Cin = cin; Sub = sub;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    step();
    lat = 1;
    in_valid = 1'b0;
    A = ~a; B = ~b; Cin = ~cin; Sub = ~sub;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(ST));
    check({tag, ".sum"},  64'(Sum),  64'(es));
    check({tag, ".cout"}, 64'(Cout), 64'(ec));
    check({tag, ".ovf"},  64'(Ovf),  64'(eo));
    check({tag, ".zero"}, 64'(Zero), 64'(ez));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] expq[$];
    logic [34:0] e;
    logic [31:0] ba[8];
    logic [31:0] bb[8];
    logic        bc[8];
    logic        bs[8];
    int          sent;
    int          got;
    int          cyc;
    int          acc_at_drop;
    int          extra;
    logic        s_ir;
    logic        s_ov;

    // Reset then idle
    rst_n = 1'b0;
    step();
    step();
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.sum",       64'(Sum),       64'(0));
    check("rst.zero",      64'(Zero),      64'(0));
    check("rst.cout",      64'(Cout),      64'(0));
    check("rst.ovf",       64'(Ovf),       64'(0));
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_after", 64'(in_ready), 64'(1));

    // Directed vectors with hand-computed results
    run_one("add_1_2",  32'h1,        32'h2,        1'b0, 1'b0, 32'h3,        1'b0, 1'b0, 1'b0);
    run_one("chain",    32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    run_one("ovf_pos",  32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_one("sub_5_7",  32'h5,        32'h7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_7_5b", 32'h7,        32'h5,        1'b1, 1'b1, 32'h1,        1'b1, 1'b0, 1'b0);
    run_one("sub_ovf",  32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_one("add_mix",  32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0);
    run_one("sub_eq",   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1);

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 3..9
    for (int i = 0; i < 8; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
      bc[i] = 1'($urandom_range(0, 1));
      bs[i] = 1'(i % 2);
    end
    sent = 0;
    got = 0;
    cyc = 0;
    acc_at_drop = -1;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 9);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        A = ba[sent]; B = bb[sent]; Cin = bc[sent]; Sub = bs[sent];
      end
      #1;
      s_ir = in_ready;
      s_ov = out_valid;
      if (!s_ir && acc_at_drop < 0) acc_at_drop = sent;
      if (cyc == 10) check("bp.restart_in_ready", 64'(s_ir), 64'(1));
      if (s_ov && out_ready) begin
        if (expq.size() == 0) begin
          check("bp.extra_result", 64'(1), 64'(0));
        end else begin
          e = expq.pop_front();
          check("bp.sum",  64'(Sum),  64'(e[31:0]));
          check("bp.cout", 64'(Cout), 64'(e[34]));
          check("bp.ovf",  64'(Ovf),  64'(e[33]));
          check("bp.zero", 64'(Zero), 64'(e[32]));
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (in_valid && s_ir) begin
        expq.push_back(model(A, B, Cin, Sub));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp.accepted", 64'(sent), 64'(8));
    check("bp.results",  64'(got),  64'(8));
    check("bp.held_at_drop", 64'(acc_at_drop), 64'(4));
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      step();
    end
    check("bp.no_duplicates", 64'(extra), 64'(0));

    // Reset mid-stream with 3 beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = 32'(i + 10); B = 32'h1; Cin = 1'b0; Sub = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("rstmid.out_valid", 64'(out_valid), 64'(0));
    step();
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      if (out_valid) extra++;
      step();
    end
    check("rstmid.no_ghost", 64'(extra), 64'(0));
    run_one("post_rst", 32'h2, 32'h2, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
